// File: rtl/des_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : des_pkg
//  Description : Shared types, DES permutation tables, S-box contents and
//                the expansion / P-permutation helpers used by the round
//                stage. Table entries use DES 1-based bit positions, where
//                position 1 is the MSB of the vector.
//  Revision    : 1.0 - initial release
// ============================================================================
package des_pkg;

    typedef logic [31:0] half_t;
    typedef logic [47:0] subkey_t;

    localparam int E_TABLE [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1
    };

    localparam int P_TABLE [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
    };

    // One 256-bit word per S-box: 64 nibbles, row-major (row 0 col 0 is the
    // leftmost nibble), so entry index = row*16 + col.
    localparam logic [255:0] S_TABLE [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
    };

    // E expansion: 32-bit half to 48 bits.
    function automatic subkey_t des_expand(input half_t r);
        subkey_t e;
        e = '0;
        for (int i = 0; i < 48; i++) begin
            e[6'(47 - i)] = r[5'(32 - E_TABLE[i])];
        end
        return e;
    endfunction

    // P permutation of the concatenated S-box outputs.
    function automatic half_t des_permute_p(input half_t s);
        half_t p;
        p = '0;
        for (int i = 0; i < 32; i++) begin
            p[5'(31 - i)] = s[5'(32 - P_TABLE[i])];
        end
        return p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/des_round_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : des_round_stage_if
//  Description : Upstream and downstream valid/ready channels of one DES
//                round stage.
//  Ports       : in_valid/in_ready/in_l/in_r/in_key  - upstream beat
//                out_valid/out_ready/out_l/out_r     - downstream beat
//                master : the traffic source/sink surrounding the stage
//                slave  : the round stage itself
//  Revision    : 1.0 - initial release
// ============================================================================
interface des_round_stage_if;
    import des_pkg::*;

    logic    in_valid;
    logic    in_ready;
    half_t   in_l;
    half_t   in_r;
    subkey_t in_key;
    logic    out_valid;
    logic    out_ready;
    half_t   out_l;
    half_t   out_r;

    modport master (
        output in_valid, in_l, in_r, in_key, out_ready,
        input  in_ready, out_valid, out_l, out_r
    );

    modport slave (
        input  in_valid, in_l, in_r, in_key, out_ready,
        output in_ready, out_valid, out_l, out_r
    );
endinterface
`default_nettype wire

// File: rtl/des_sbox.sv
`default_nettype none
// ============================================================================
//  Module      : des_sbox
//  Description : One DES 6-to-4 substitution box; contents set by TABLE.
//  Ports       : x - 6-bit chunk, x[5],x[0] select the row, x[4:1] the column
//                y - 4-bit substitution result
//  Revision    : 1.0 - initial release
// ============================================================================
module des_sbox #(
    parameter logic [255:0] TABLE = '0
) (
    input  wire logic [5:0] x,
    output logic      [3:0] y
);
    logic [5:0] idx;
    logic [7:0] base;

    // {row, col} is exactly row*16 + col.
    assign idx  = {x[5], x[0], x[4:1]};
    // Entry 0 occupies the top nibble of TABLE.
    assign base = 8'd255 - {idx, 2'b00};
    assign y    = TABLE[base -: 4];
endmodule
`default_nettype wire

// File: rtl/des_sbox_layer.sv
`default_nettype none
// ============================================================================
//  Module      : des_sbox_layer
//  Description : The eight DES S-boxes side by side; combinational.
//  Ports       : x - 48-bit E(R) xor K, bits [47:42] feed sbox1
//                y - 32-bit result, sbox1 in bits [31:28]
//  Revision    : 1.0 - initial release
// ============================================================================
module des_sbox_layer
    import des_pkg::*;
(
    input  wire subkey_t x,
    output half_t        y
);
    des_sbox #(.TABLE(S_TABLE[0])) sbox1 (.x(x[47:42]), .y(y[31:28]));
    des_sbox #(.TABLE(S_TABLE[1])) sbox2 (.x(x[41:36]), .y(y[27:24]));
    des_sbox #(.TABLE(S_TABLE[2])) sbox3 (.x(x[35:30]), .y(y[23:20]));
    des_sbox #(.TABLE(S_TABLE[3])) sbox4 (.x(x[29:24]), .y(y[19:16]));
    des_sbox #(.TABLE(S_TABLE[4])) sbox5 (.x(x[23:18]), .y(y[15:12]));
    des_sbox #(.TABLE(S_TABLE[5])) sbox6 (.x(x[17:12]), .y(y[11:8]));
    des_sbox #(.TABLE(S_TABLE[6])) sbox7 (.x(x[11:6]),  .y(y[7:4]));
    des_sbox #(.TABLE(S_TABLE[7])) sbox8 (.x(x[5:0]),   .y(y[3:0]));
endmodule
`default_nettype wire

// File: rtl/des_round_stage.sv
`default_nettype none
// ============================================================================
//  Module      : des_round_stage
//  Description : Two-stage pipelined DES Feistel round with valid/ready on
//                both sides. S1 registers E(R) xor K plus L and R; S2
//                registers the swapped (or, for the last round, unswapped)
//                halves after S-box, P and the xor with L.
//  Ports       : clk   - rising-edge clock
//                rst_n - asynchronous active-low reset
//                bus   - slave view of des_round_stage_if
//  Parameters  : LAST_ROUND - nonzero suppresses the L/R swap (round 16)
//  Revision    : 1.0 - initial release
// ============================================================================
module des_round_stage
    import des_pkg::*;
#(
    parameter int LAST_ROUND = 0
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    des_round_stage_if.slave  bus
);
    subkey_t s1_x;
    half_t   s1_l;
    half_t   s1_r;
    logic    s1_v;
    half_t   s2_l;
    half_t   s2_r;
    logic    s2_v;

    logic    s2_adv;
    logic    accept;
    half_t   sbox_out;
    half_t   f;
    half_t   next_l;
    half_t   next_r;

    // S2 can take S1's beat when it is empty or being drained this cycle,
    // which lets a full pipe stream without bubbles.
    assign s2_adv       = s1_v && (!s2_v || bus.out_ready);
    assign bus.in_ready = !s1_v || s2_adv;
    assign accept       = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_x <= '0;
            s1_l <= '0;
            s1_r <= '0;
            s1_v <= 1'b0;
        end else if (accept) begin
            s1_x <= des_expand(bus.in_r) ^ bus.in_key;
            s1_l <= bus.in_l;
            s1_r <= bus.in_r;
            s1_v <= 1'b1;
        end else if (s2_adv) begin
            s1_v <= 1'b0;
        end
    end

    des_sbox_layer u_sbox_layer (
        .x (s1_x),
        .y (sbox_out)
    );

    assign f = des_permute_p(sbox_out);

    generate
        if (LAST_ROUND != 0) begin : g_last_round
            assign next_l = s1_l ^ f;
            assign next_r = s1_r;
        end else begin : g_inner_round
            assign next_l = s1_r;
            assign next_r = s1_l ^ f;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_l <= '0;
            s2_r <= '0;
            s2_v <= 1'b0;
        end else if (s2_adv) begin
            s2_l <= next_l;
            s2_r <= next_r;
            s2_v <= 1'b1;
        end else if (s2_v && bus.out_ready) begin
            s2_v <= 1'b0;
        end
    end

    assign bus.out_valid = s2_v;
    assign bus.out_l     = s2_l;
    assign bus.out_r     = s2_r;
endmodule
`default_nettype wire

// File: tb/tb_des_round_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_des_round_stage
//  Description : Directed bench for des_round_stage (inner and last round).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_des_round_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_l = '0;
    logic [31:0] in_r = '0;
    logic [47:0] in_key = '0;
    logic        out_ready = 1'b0;

    int total = 0;
    int bad = 0;
    int accepts = 0;
    int a0;
    int cyc;
    logic        hold_pending = 1'b0;
    logic [63:0] held = '0;
    logic [63:0] exp_q [$];

    always #5 clk = ~clk;

    des_round_stage_if bus0 ();
    des_round_stage_if bus1 ();

    assign bus0.in_valid  = in_valid;
    assign bus0.in_l      = in_l;
    assign bus0.in_r      = in_r;
    assign bus0.in_key    = in_key;
    assign bus0.out_ready = out_ready;
    assign bus1.in_valid  = in_valid;
    assign bus1.in_l      = in_l;
    assign bus1.in_r      = in_r;
    assign bus1.in_key    = in_key;
    assign bus1.out_ready = out_ready;

    des_round_stage #(.LAST_ROUND(0)) dut      (.clk(clk), .rst_n(rst_n), .bus(bus0));
    des_round_stage #(.LAST_ROUND(1)) dut_last (.clk(clk), .rst_n(rst_n), .bus(bus1));

    // Reference tables written out independently in decimal.
    localparam int ET [48] = '{32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,12,13,14,15,16,17,
                               16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32,1};
    localparam int PT [32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                               2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
    localparam int SB [8][64] = '{
        '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
          4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
        '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
          0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
        '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
          13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
        '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
          10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
        '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
          4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
        '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
          9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
        '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
          1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
        '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
          7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
    };

    function automatic logic [31:0] f_model(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s;
        logic [31:0] p;
        logic [5:0]  c;
        int          row;
        int          col;
        for (int i = 0; i < 48; i++) x[47 - i] = r[32 - ET[i]];
        x = x ^ k;
        for (int b = 0; b < 8; b++) begin
            c   = x[47 - 6 * b -: 6];
            row = 2 * int'(c[5]) + int'(c[0]);
            col = int'(c[4:1]);
            s[31 - 4 * b -: 4] = 4'(SB[b][row * 16 + col]);
        end
        for (int i = 0; i < 32; i++) p[31 - i] = s[32 - PT[i]];
        return p;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: at the falling edge score any output transfer, check that a
    // stalled output stayed put, and log any input accept; then cross the
    // rising edge and return 1 time unit after it.
    task automatic tick();
        logic [63:0] e;
        @(negedge clk);
        if (bus0.out_valid && out_ready) begin
            chk("sb_has_entry", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("stream_data", {bus0.out_l, bus0.out_r}, e);
            end
        end
        if (hold_pending) begin
            chk("hold_valid", 64'(bus0.out_valid), 64'd1);
            chk("hold_data", {bus0.out_l, bus0.out_r}, held);
        end
        hold_pending = bus0.out_valid && !out_ready;
        held = {bus0.out_l, bus0.out_r};
        if (in_valid && bus0.in_ready) begin
            exp_q.push_back({in_r, in_l ^ f_model(in_r, in_key)});
            accepts++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_beat();
        in_l   = $urandom;
        in_r   = $urandom;
        in_key = {16'($urandom), $urandom};
    endtask

    initial begin
        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(bus0.out_valid), 64'd0);
        chk("rst_out_lr", {bus0.out_l, bus0.out_r}, 64'd0);
        rst_n = 1'b1;
        chk("rst_in_ready", 64'(bus0.in_ready), 64'd1);

        // ---------------- FIPS round-1 vector ----------------
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_l      = 32'hCC00CCFF;
        in_r      = 32'hF0AAF0AA;
        in_key    = 48'h1B02EFFC7072;
        tick();
        in_valid  = 1'b0;
        in_key    = '0;
        chk("fips_s1_x", 64'(dut.s1_x), 64'h6117BA866527);
        chk("fips_f", 64'(dut.f), 64'h234AA9BB);
        chk("fips_lat1_valid", 64'(bus0.out_valid), 64'd0);
        tick();
        chk("fips_lat2_valid", 64'(bus0.out_valid), 64'd1);
        chk("fips_out", {bus0.out_l, bus0.out_r}, 64'hF0AAF0AA_EF4A6544);
        chk("fips_last_valid", 64'(bus1.out_valid), 64'd1);
        chk("fips_last_out", {bus1.out_l, bus1.out_r}, 64'hEF4A6544_F0AAF0AA);
        tick();
        chk("fips_drained", 64'(bus0.out_valid), 64'd0);

        // ---------------- streaming, 16 back-to-back beats ----------------
        a0 = accepts;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            rand_beat();
            chk("stream_in_ready", 64'(bus0.in_ready), 64'd1);
            tick();
        end
        in_valid = 1'b0;
        repeat (3) tick();
        chk("stream_accepts", 64'(accepts - a0), 64'd16);
        chk("stream_q_empty", 64'(exp_q.size()), 64'd0);

        // ---------------- backpressure ----------------
        out_ready = 1'b0;
        a0 = accepts;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            rand_beat();
            tick();
        end
        chk("bp_accepts", 64'(accepts - a0), 64'd2);
        chk("bp_in_ready", 64'(bus0.in_ready), 64'd0);
        chk("bp_out_valid", 64'(bus0.out_valid), 64'd1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();
        chk("bp_q_empty", 64'(exp_q.size()), 64'd0);

        // ---------------- random handshake, 1000 beats ----------------
        a0  = accepts;
        cyc = 0;
        while ((accepts - a0) < 1000 && cyc < 20000) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 4) != 0;
            rand_beat();
            tick();
            cyc++;
        end
        chk("rand_accepts", 64'(accepts - a0), 64'd1000);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();
        chk("rand_q_empty", 64'(exp_q.size()), 64'd0);

        // ---------------- mid-flight reset ----------------
        out_ready = 1'b0;
        in_valid  = 1'b1;
        rand_beat();
        repeat (3) tick();
        in_valid = 1'b0;
        chk("mr_full_valid", 64'(bus0.out_valid), 64'd1);
        chk("mr_full_in_ready", 64'(bus0.in_ready), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_async_valid", 64'(bus0.out_valid), 64'd0);
        chk("mr_async_lr", {bus0.out_l, bus0.out_r}, 64'd0);
        exp_q.delete();
        hold_pending = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("mr_in_ready", 64'(bus0.in_ready), 64'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mr_no_stale", 64'(bus0.out_valid), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
